// File: rtl/mosi_command_sequencer_if.sv
// Aux command RAM bus and MOSI command output bundle for one SPI headstage port.
// master = sequencer side, slave = RAM/shift-register side.
interface mosi_command_sequencer_if #(
   parameter int NUM_AUX = 3,
   parameter int AUX_AW  = 10,
   parameter int CHAN_W  = 6
);
   logic [NUM_AUX*16-1:0]     aux_cmd;
   logic [NUM_AUX*AUX_AW-1:0] aux_end;
   logic [NUM_AUX*AUX_AW-1:0] aux_loop;
   logic [NUM_AUX*AUX_AW-1:0] aux_index;
   logic [CHAN_W-1:0]         channel;
   logic [15:0]               MOSI_cmd;
   logic                      cmd_valid;
   logic                      frame_done;

   modport master (
      input  aux_cmd, aux_end, aux_loop,
      output aux_index, channel, MOSI_cmd, cmd_valid, frame_done
   );

   modport slave (
      output aux_cmd, aux_end, aux_loop,
      input  aux_index, channel, MOSI_cmd, cmd_valid, frame_done
   );
endinterface

// File: rtl/mosi_command_sequencer.sv
// Per-frame MOSI command sequencer: CONVERT slots then aux slots with looping RAM indices.
// Optional macro MOSI_DIGOUT_OVERRIDE_EN forces digout_override into the LSB of register-3 aux writes.
module mosi_command_sequencer #(
   parameter int NUM_CONVERT = 32,
   parameter int NUM_AUX     = 3,
   parameter int AUX_AW      = 10,
   parameter int CHAN_W      = 6
) (
   input  logic dataclk,
   input  logic reset_n,
   input  logic run,
   input  logic slot_strobe,
   input  logic DSP_settle,
   input  logic digout_override,
   output logic busy,
   mosi_command_sequencer_if.master bus
);

   localparam logic [CHAN_W-1:0] LAST_SLOT = CHAN_W'(NUM_CONVERT + NUM_AUX - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

   state_t            state_reg, state_next;
   logic [CHAN_W-1:0] channel_reg, channel_next;
   logic [15:0]       mosi_cmd_reg;
   logic [15:0]       cmd_word;
   logic [15:0]       aux_word;
   logic [15:0]       aux_out;
   logic              cmd_valid_reg;
   logic              frame_done_reg;
   logic              settle_reg;
   logic              settle_eff;
   logic [5:0]        chan6;
   logic              fire;
   logic              is_last;

   assign fire    = slot_strobe && (state_reg != IDLE);
   assign is_last = (channel_reg == LAST_SLOT);

   always_comb begin
      channel_next = channel_reg;
      if (fire) channel_next = is_last ? '0 : channel_reg + CHAN_W'(1);
   end

   // Leaving ACTIVE looks at the post-strobe channel so a strobe in the same cycle is never lost.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (run) state_next = ACTIVE;
         ACTIVE:  if (!run) state_next = (channel_next == '0) ? IDLE : FLUSH;
         FLUSH:   if (fire && is_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      aux_word = '0;
      for (int k = 0; k < NUM_AUX; k++) begin
         if (channel_reg == CHAN_W'(NUM_CONVERT + k)) aux_word = bus.aux_cmd[16*k +: 16];
      end
   end

`ifdef MOSI_DIGOUT_OVERRIDE_EN
   always_comb begin
      aux_out = aux_word;
      if (aux_word[15:8] == 8'h83) aux_out = {aux_word[15:1], digout_override};
   end
`else
   logic unused_digout;
   assign unused_digout = digout_override;
   assign aux_out       = aux_word;
`endif

   // Slot 0 takes the live settle request; later slots reuse the value latched there.
   assign settle_eff = (channel_reg == '0) ? DSP_settle : settle_reg;
   assign chan6      = 6'(channel_reg);

   always_comb begin
      cmd_word = aux_out;
      if (channel_reg < CHAN_W'(NUM_CONVERT)) cmd_word = {2'b00, chan6, 7'b0, settle_eff};
   end

   always_ff @(posedge dataclk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         channel_reg    <= '0;
         mosi_cmd_reg   <= '0;
         cmd_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         settle_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         channel_reg    <= channel_next;
         cmd_valid_reg  <= fire;
         frame_done_reg <= fire && is_last;
         if (fire) mosi_cmd_reg <= cmd_word;
         if (fire && channel_reg == '0) settle_reg <= DSP_settle;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_AUX; gi++) begin : g_aux
         logic [AUX_AW-1:0] index_reg;
         logic [AUX_AW-1:0] end_idx;
         logic [AUX_AW-1:0] loop_idx;

         assign end_idx  = bus.aux_end[gi*AUX_AW +: AUX_AW];
         assign loop_idx = bus.aux_loop[gi*AUX_AW +: AUX_AW];

         always_ff @(posedge dataclk or negedge reset_n) begin
            if (!reset_n) begin
               index_reg <= '0;
            end else if (fire && channel_reg == CHAN_W'(NUM_CONVERT + gi)) begin
               index_reg <= (index_reg == end_idx) ? loop_idx : index_reg + AUX_AW'(1);
            end
         end

         assign bus.aux_index[gi*AUX_AW +: AUX_AW] = index_reg;
      end
   endgenerate

   assign bus.channel    = channel_reg;
   assign bus.MOSI_cmd   = mosi_cmd_reg;
   assign bus.cmd_valid  = cmd_valid_reg;
   assign bus.frame_done = frame_done_reg;
   assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_mosi_command_sequencer.sv
// Scoreboard bench for mosi_command_sequencer: stimulus pushes expected commands, a negedge monitor pops them.
module tb_mosi_command_sequencer;

   localparam int NC = 32;
   localparam int NA = 3;
   localparam int AW = 10;
   localparam int CW = 6;

   logic clk = 1'b0;
   logic reset_n, run, slot_strobe, DSP_settle, digout_override, busy;

   always #5 clk = ~clk;

   mosi_command_sequencer_if #(.NUM_AUX(NA), .AUX_AW(AW), .CHAN_W(CW)) bus ();

   mosi_command_sequencer #(.NUM_CONVERT(NC), .NUM_AUX(NA), .AUX_AW(AW), .CHAN_W(CW)) dut (
      .dataclk(clk), .reset_n(reset_n), .run(run), .slot_strobe(slot_strobe),
      .DSP_settle(DSP_settle), .digout_override(digout_override), .busy(busy), .bus(bus)
   );

   int checks = 0;
   int fails  = 0;

   logic [AW-1:0] end_v [NA];
   logic [AW-1:0] loop_v [NA];
   logic          force_en;
   logic [15:0]   force_word;

   // Bench-side model state
   int            exp_chan;
   logic [AW-1:0] exp_idx [NA];
   logic          settle_m;
   logic [16:0]   exp_q [$];

   // Hand-computed aux index at the start of frames 0..6
   int idx0_list [7] = '{0, 1, 2, 1, 2, 1, 2};
   int idx1_list [7] = '{0, 1, 2, 3, 4, 5, 0};
   int idx2_list [7] = '{0, 3, 4, 5, 6, 7, 8};

   assign bus.aux_end  = {end_v[2], end_v[1], end_v[0]};
   assign bus.aux_loop = {loop_v[2], loop_v[1], loop_v[0]};

   function automatic logic [15:0] ram_word(input int k, input logic [AW-1:0] idx);
      if (force_en && k == 0) return force_word;
      return 16'hA000 | 16'(k << 8) | {8'h00, idx[7:0]};
   endfunction

   always_comb begin
      for (int k = 0; k < NA; k++) bus.aux_cmd[16*k +: 16] = ram_word(k, bus.aux_index[AW*k +: AW]);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic check_zero_state(input string tag);
      check({tag, " channel"}, 32'(bus.channel), 0);
      check({tag, " MOSI_cmd"}, 32'(bus.MOSI_cmd), 0);
      check({tag, " cmd_valid"}, 32'(bus.cmd_valid), 0);
      check({tag, " frame_done"}, 32'(bus.frame_done), 0);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " aux_index"}, 32'(bus.aux_index), 0);
   endtask

   task automatic push_expect();
      logic [15:0] w;
      logic        fd;
      int          k;
      if (exp_chan < NC) begin
         if (exp_chan == 0) settle_m = DSP_settle;
         w = {2'b00, 6'(exp_chan), 7'b0, settle_m};
      end else begin
         k = exp_chan - NC;
         w = ram_word(k, exp_idx[k]);
`ifdef MOSI_DIGOUT_OVERRIDE_EN
         if (w[15:8] == 8'h83) w = {w[15:1], digout_override};
`endif
         exp_idx[k] = (exp_idx[k] == end_v[k]) ? loop_v[k] : exp_idx[k] + AW'(1);
      end
      fd = (exp_chan == NC + NA - 1);
      exp_chan = fd ? 0 : exp_chan + 1;
      exp_q.push_back({fd, w});
   endtask

   // n back-to-back strobes, each one expected to issue a slot
   task automatic issue(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         push_expect();
         slot_strobe = 1'b1;
      end
      @(posedge clk); #1;
      slot_strobe = 1'b0;
   endtask

   task automatic issue_gap(input int n);
      for (int i = 0; i < n; i++) begin
         issue(1);
         @(posedge clk); #1;
      end
   endtask

   task automatic idle_strobes(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 slot_strobe = 1'b1;
         @(posedge clk); #1 slot_strobe = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      logic [16:0] e;
      if (bus.cmd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_cmd: got %04h with cmd_valid, required no command", bus.MOSI_cmd);
         end else begin
            e = exp_q.pop_front();
            if ({bus.frame_done, bus.MOSI_cmd} !== e) begin
               fails++;
               $display("FAIL cmd: got fd=%0b cmd=%04h required fd=%0b cmd=%04h",
                        bus.frame_done, bus.MOSI_cmd, e[16], e[15:0]);
            end else begin
               $display("cmd %04h fd=%0b ok", bus.MOSI_cmd, bus.frame_done);
            end
         end
      end else if (bus.frame_done) begin
         checks++;
         fails++;
         $display("FAIL frame_done_alone: got 1 required 0");
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; run = 1'b0; slot_strobe = 1'b0; DSP_settle = 1'b0; digout_override = 1'b0;
      force_en = 1'b0; force_word = 16'h0000;
      end_v[0] = 10'd2; loop_v[0] = 10'd1;
      end_v[1] = 10'd5; loop_v[1] = 10'd0;
      end_v[2] = 10'd0; loop_v[2] = 10'd3;
      exp_chan = 0; settle_m = 1'b0;
      for (int k = 0; k < NA; k++) exp_idx[k] = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero_state("reset");
      @(posedge clk); #1 reset_n = 1'b1;

      idle_strobes(2);
      @(negedge clk);
      check("idle busy", 32'(busy), 0);
      check("idle channel", 32'(bus.channel), 0);

      @(posedge clk); #1 run = 1'b1; DSP_settle = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("active busy", 32'(busy), 1);

      for (int f = 0; f < 7; f++) begin
         if (f == 5) begin force_en = 1'b1; force_word = 16'h8300; digout_override = 1'b1; end
         if (f == 6) force_word = 16'h8200;
         issue(10);
         if (f == 2) DSP_settle = 1'b0;
         issue_gap(22);
         @(negedge clk);
         check("aux_index0 slot32", 32'(bus.aux_index[0 +: AW]), idx0_list[f]);
         check("aux_index1 slot32", 32'(bus.aux_index[AW +: AW]), idx1_list[f]);
         check("aux_index2 slot32", 32'(bus.aux_index[2*AW +: AW]), idx2_list[f]);
         issue(1);
         check("aux_index1 after slot32", 32'(bus.aux_index[AW +: AW]), idx1_list[f]);
         check("aux_index2 after slot32", 32'(bus.aux_index[2*AW +: AW]), idx2_list[f]);
`ifdef MOSI_DIGOUT_OVERRIDE_EN
         if (f == 5) check("reg3 override", 32'(bus.MOSI_cmd), 32'h8301);
`else
         if (f == 5) check("reg3 passthru", 32'(bus.MOSI_cmd), 32'h8300);
`endif
         if (f == 6) check("reg2 passthru", 32'(bus.MOSI_cmd), 32'h8200);
         issue(2);
         @(negedge clk);
         check("frame end channel", 32'(bus.channel), 0);
      end
      force_en = 1'b0; digout_override = 1'b0;

      // run dropped mid-frame: frame is flushed to the end
      issue(13);
      run = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("flush busy", 32'(busy), 1);
      check("flush channel", 32'(bus.channel), 13);
      issue_gap(22);
      @(negedge clk);
      check("post-flush busy", 32'(busy), 0);
      check("post-flush channel", 32'(bus.channel), 0);
      idle_strobes(3);

      // reset mid-frame
      @(posedge clk); #1 run = 1'b1; DSP_settle = 1'b1;
      @(posedge clk); #1;
      issue(20);
      @(negedge clk); #1 reset_n = 1'b0;
      #1 check_zero_state("midframe reset");
      exp_chan = 0;
      for (int k = 0; k < NA; k++) exp_idx[k] = '0;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      issue(32);
      @(negedge clk);
      check("restart aux_index", 32'(bus.aux_index), 0);
      issue(3);
      @(negedge clk);
      check("restart channel", 32'(bus.channel), 0);

      repeat (3) @(posedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
